// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command/reply bytes and frame edge indices.
// Imported by the host transmitter and by the keyboard receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQ,
    ST_CLOCKING,
    ST_WAIT_IDLE,
    ST_DONE,
    ST_ERR
  } ps2_tx_state_e;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;

  localparam logic [7:0] ACK    = 8'hFA;
  localparam logic [7:0] RESEND = 8'hFE;

  localparam logic [7:0] BREAK = 8'hF0;
  localparam logic [7:0] EXT   = 8'hE0;

  // Device clock falling-edge numbers within one host-to-device frame
  localparam logic [3:0] EDGE_LAST_DATA = 4'd8;
  localparam logic [3:0] EDGE_PARITY    = 4'd9;
  localparam logic [3:0] EDGE_STOP      = 4'd10;

  function automatic logic oddParity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Three-flop synchronizer for one raw PS/2 pad, with a one-cycle falling-edge pulse.
// Shared by the host transmitter and the keyboard receiver.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_pad,
  output logic o_level,
  output logic o_fall
);

  logic [2:0] r_sync;
  logic       r_prev;

  // Pads idle high, so reset to the released level to avoid a false edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= 3'b111;
      r_prev <= 1'b1;
    end else begin
      r_sync <= {r_sync[1:0], i_pad};
      r_prev <= r_sync[2];
    end
  end

  assign o_level = r_sync[2];
  assign o_fall  = r_prev & ~r_sync[2];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: clock inhibit, request-to-send, bit shifting on device
// clock falling edges, ACK check, then wait for the bus to go idle.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  ps2_tx_state_e    r_state, w_stateNxt;
  logic [7:0]       r_byte, w_byteNxt;
  logic             r_parity, w_parityNxt;
  logic [INH_W-1:0] r_inhCnt, w_inhCntNxt;
  logic [TMO_W-1:0] r_tmoCnt, w_tmoCntNxt;
  logic [3:0]       r_edgeCnt, w_edgeCntNxt;
  logic [3:0]       w_edgeNum;
  logic             w_dataBit;

  logic r_clkOe, r_dataOe, r_ready, r_done, r_err;
  logic w_clkOeNxt, w_dataOeNxt;

  logic w_clkLevel, w_clkFall, w_dataLevel, w_dataFall;

  ps2_sync_edge u_syncClk (
    .clk     (clk),
    .rst     (rst),
    .i_pad   (ps2_clk),
    .o_level (w_clkLevel),
    .o_fall  (w_clkFall)
  );

  ps2_sync_edge u_syncData (
    .clk     (clk),
    .rst     (rst),
    .i_pad   (ps2_data),
    .o_level (w_dataLevel),
    .o_fall  (w_dataFall)
  );

  // All outputs are registered from the next state, so they line up with the state itself
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_byte    <= 8'h00;
      r_parity  <= 1'b0;
      r_inhCnt  <= '0;
      r_tmoCnt  <= '0;
      r_edgeCnt <= 4'd0;
      r_clkOe   <= 1'b0;
      r_dataOe  <= 1'b0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_stateNxt;
      r_byte    <= w_byteNxt;
      r_parity  <= w_parityNxt;
      r_inhCnt  <= w_inhCntNxt;
      r_tmoCnt  <= w_tmoCntNxt;
      r_edgeCnt <= w_edgeCntNxt;
      r_clkOe   <= w_clkOeNxt;
      r_dataOe  <= w_dataOeNxt;
      r_ready   <= (w_stateNxt == ST_IDLE);
      r_done    <= (w_stateNxt == ST_DONE);
      r_err     <= (w_stateNxt == ST_ERR);
    end
  end

  assign w_edgeNum = r_edgeCnt + 4'd1;

  always_comb begin
    w_stateNxt   = r_state;
    w_byteNxt    = r_byte;
    w_parityNxt  = r_parity;
    w_inhCntNxt  = r_inhCnt;
    w_tmoCntNxt  = r_tmoCnt;
    w_edgeCntNxt = r_edgeCnt;
    w_dataBit    = r_dataOe;

    case (r_state)
      ST_IDLE: begin
        if (tx_valid && r_ready) begin
          w_byteNxt   = tx_data;
          w_parityNxt = oddParity(tx_data);
          w_inhCntNxt = '0;
          w_stateNxt  = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (r_inhCnt == INH_LAST) w_stateNxt = ST_REQ;
        else                      w_inhCntNxt = r_inhCnt + INH_W'(1);
      end
      ST_REQ: begin
        w_tmoCntNxt  = '0;
        w_edgeCntNxt = 4'd0;
        w_stateNxt   = ST_CLOCKING;
      end
      // Each device falling edge moves the pad to the next bit; edge 11 reads the ACK
      ST_CLOCKING: begin
        if (w_clkFall) begin
          w_tmoCntNxt  = '0;
          w_edgeCntNxt = w_edgeNum;
          if (w_edgeNum <= EDGE_LAST_DATA)   w_dataBit = ~r_byte[r_edgeCnt[2:0]];
          else if (w_edgeNum == EDGE_PARITY) w_dataBit = ~r_parity;
          else if (w_edgeNum == EDGE_STOP)   w_dataBit = 1'b0;
          else w_stateNxt = w_dataLevel ? ST_ERR : ST_WAIT_IDLE;
        end else if (r_tmoCnt == TMO_LAST) begin
          w_stateNxt = ST_ERR;
        end else begin
          w_tmoCntNxt = r_tmoCnt + TMO_W'(1);
        end
      end
      // A data fall here means the device is still busy, so the idle wait restarts
      ST_WAIT_IDLE: begin
        if (w_clkLevel && w_dataLevel)  w_stateNxt = ST_DONE;
        else if (w_dataFall)            w_tmoCntNxt = '0;
        else if (r_tmoCnt == TMO_LAST)  w_stateNxt = ST_ERR;
        else                            w_tmoCntNxt = r_tmoCnt + TMO_W'(1);
      end
      ST_DONE:  w_stateNxt = ST_IDLE;
      ST_ERR:   w_stateNxt = ST_IDLE;
      default:  w_stateNxt = ST_IDLE;
    endcase

    w_clkOeNxt  = (w_stateNxt == ST_INHIBIT) || (w_stateNxt == ST_REQ);
    w_dataOeNxt = 1'b0;
    if (w_stateNxt == ST_REQ)           w_dataOeNxt = 1'b1;
    else if (w_stateNxt == ST_CLOCKING) w_dataOeNxt = w_dataBit;
  end

  assign ps2_clk_oe  = r_clkOe;
  assign ps2_data_oe = r_dataOe;
  assign tx_ready    = r_ready;
  assign tx_done     = r_done;
  assign tx_err      = r_err;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a behavioural keyboard drives the open-drain pads and a
// monitor checks every tx_done/tx_err pulse against expectations queued at send time.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TMO  = 400;
  localparam int HALF = 12;

  localparam int MODE_ACK    = 0;
  localparam int MODE_NACK   = 1;
  localparam int MODE_SILENT = 2;
  localparam int MODE_ABORT  = 3;

  typedef struct {
    bit         isErr;
    bit         isTimeout;
    bit         checkFrame;
    logic [7:0] data;
  } exp_t;

  exp_t expQ[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk, ps2_data, ps2_clk_oe, ps2_data_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err;

  logic       devClkLow = 1'b0;
  logic       devDataLow = 1'b0;
  logic [9:0] recvFrame = '0;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  int clkFallCycle = 0;
  int clkHighRun = 0;
  int pulseCount = 0;
  int holdViol = 0;
  bit holdActive = 0;
  bit readyPending = 0;
  logic clkOePrev = 1'b0, dataOePrev1 = 1'b0, dataOePrev2 = 1'b0;

  assign ps2_clk  = ~(ps2_clk_oe | devClkLow);
  assign ps2_data = ~(ps2_data_oe | devDataLow);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_err      (tx_err)
  );

  // Frame as the device sees it: 8 data bits LSB first, odd parity, stop bit 1
  function automatic logic [9:0] frameOf(input logic [7:0] b);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Monitor: inhibit shape on every request, and scoreboard pop on every result pulse
  always @(negedge clk) begin
    exp_t e;
    cycle++;
    if (readyPending) begin
      checkOutput("ready_after_pulse", 32'(tx_ready), 1);
      readyPending = 0;
    end
    if (ps2_clk_oe) clkHighRun++;
    if (clkOePrev && !ps2_clk_oe) begin
      clkFallCycle = cycle;
      checkOutput("inhibit_len", clkHighRun, INH + 1);
      checkOutput("start_lead", {dataOePrev2, dataOePrev1, ps2_data_oe}, 3'b011);
    end
    if (!ps2_clk_oe) clkHighRun = 0;
    if (holdActive && tx_valid && tx_ready) holdViol++;
    if (tx_done || tx_err) begin
      pulseCount++;
      readyPending = 1;
      checkOutput("exclusive", 32'(tx_done & tx_err), 0);
      checkOutput("oe_at_pulse", {ps2_clk_oe, ps2_data_oe}, 0);
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_pulse: got done=%0b err=%0b want none", tx_done, tx_err);
      end else begin
        e = expQ.pop_front();
        checkOutput("pulse_kind", {tx_done, tx_err}, e.isErr ? 2'b01 : 2'b10);
        if (e.checkFrame) checkOutput("frame", recvFrame, frameOf(e.data));
        if (e.isTimeout)
          checkOutput("timeout_time", 32'((cycle - clkFallCycle >= TMO) &&
                                          (cycle - clkFallCycle <= TMO + 1)), 1);
      end
    end
    dataOePrev2 = dataOePrev1;
    dataOePrev1 = ps2_data_oe;
    clkOePrev   = ps2_clk_oe;
  end

  // Keyboard model: waits for request-to-send, then generates 11 clocks and samples each bit
  task automatic runDevice(input int mode);
    int n;
    if (mode == MODE_SILENT) return;
    n = 0;
    while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < INH + 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= INH + 50) begin
      total++;
      bad++;
      $display("[TB] FAIL request_to_send: got no start bit want start within %0d cycles", INH + 50);
      return;
    end
    repeat (3) @(negedge clk);
    for (int k = 1; k <= 11; k++) begin
      devClkLow = 1'b1;
      repeat (HALF) @(negedge clk);
      if (k <= 10) recvFrame[k-1] = ps2_data;
      devClkLow = 1'b0;
      if (k == 10 && mode != MODE_NACK) devDataLow = 1'b1;
      if (k == 11) devDataLow = 1'b0;
      if (mode == MODE_ABORT && k == 5) return;
      repeat (HALF) @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int mode);
    exp_t e;
    int   n;
    int   pulseSnap;
    n = 0;
    while (!tx_ready && n < 2 * TMO) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_before_send", 32'(tx_ready), 1);
    e.isErr      = (mode == MODE_NACK) || (mode == MODE_SILENT);
    e.isTimeout  = (mode == MODE_SILENT);
    e.checkFrame = (mode != MODE_SILENT);
    e.data       = b;
    if (mode != MODE_ABORT) expQ.push_back(e);
    pulseSnap = pulseCount;
    recvFrame = '0;
    tx_data   = b;
    tx_valid  = 1'b1;
    @(negedge clk);
    checkOutput("accept_state", {tx_ready, ps2_clk_oe}, 2'b01);
    if (mode == MODE_ABORT) begin
      tx_data    = 8'hFF;
      holdActive = 1;
    end else begin
      tx_valid = 1'b0;
    end
    runDevice(mode);
    if (mode == MODE_ABORT) begin
      holdActive = 0;
      tx_valid   = 1'b0;
      rst        = 1'b1;
      @(negedge clk);
      checkOutput("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      checkOutput("rst_ready", 32'(tx_ready), 1);
      rst = 1'b0;
      checkOutput("rst_no_pulse", pulseCount - pulseSnap, 0);
      checkOutput("held_not_accepted", holdViol, 0);
      checkOutput("bits_before_rst", recvFrame[4:0], b[4:0]);
    end else begin
      n = 0;
      while (!tx_ready && n < TMO + INH + 100) begin
        @(negedge clk);
        n++;
      end
      checkOutput("transfer_finished", 32'(tx_ready), 1);
      @(negedge clk);
      checkOutput("one_pulse", pulseCount - pulseSnap, 1);
      checkOutput("queue_drained", expQ.size(), 0);
    end
  endtask

  initial begin
    int r;
    int m;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_vals", {ps2_clk_oe, ps2_data_oe, tx_ready, tx_done, tx_err}, 5'b00100);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(8'hED, MODE_ACK);
    checkOutput("ed_frame", recvFrame, 10'b11_1110_1101);
    applyStimulus(8'h00, MODE_ACK);
    checkOutput("zero_frame", recvFrame, 10'b11_0000_0000);
    applyStimulus(8'hF4, MODE_SILENT);
    applyStimulus(8'hFF, MODE_NACK);
    applyStimulus(8'h5A, MODE_ABORT);
    repeat (4) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      r = int'($urandom_range(0, 9));
      m = (r == 0) ? MODE_SILENT : (r <= 2) ? MODE_NACK : MODE_ACK;
      applyStimulus(8'($urandom), m);
    end

    checkOutput("queue_empty_end", expQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish want finish within 1 ms");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte (LED set 8'hED, reset 8'hFF, enable 8'hF4, …) from the game logic to the keyboard using the open-drain PS/2 request-to-send protocol, then checks the device's acknowledge bit. It shares the PS/2 pads with the keyboard receiver. While `tx_ready` is low, the receiver's output is ignored by the consumer.

## Interface
- `INHIBIT_CYCLES`, default 12000: clock-low inhibit length (120 µs at 100 MHz).
- `TIMEOUT_CYCLES`, default 2000000: maximum gap between device falling edges, and maximum time in the idle wait (20 ms).
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; synchronous and active-high.
- `ps2_clk`  in  1  raw PS/2 clock pad value (asynchronous).
- `ps2_data`  in  1  raw PS/2 data pad value (asynchronous).
- `ps2_clk_oe`  out  1  1 = drive the clock pad low; 0 = release.
- `ps2_data_oe`  out  1  1 = drive the data pad low; 0 = release.
- `tx_data`  in  8  byte to send, LSB first.
- `tx_valid`  in  1  send request; accepted only when `tx_ready` is high.
- `tx_ready`  out  1  idle and able to accept a byte.
- `tx_done`  out  1  one-cycle pulse: byte sent and device ACK received.
- `tx_err`  out  1  one-cycle pulse: timeout or NACK.

## Operation
- **Input sync:** both pads pass through 3 flops. Falling edge = previous synced 1 and current synced 0.
- **States and transitions:**
  - IDLE: leave on `tx_valid & tx_ready`. Latch the byte and compute parity = ~^byte (odd parity).
  - INHIBIT: `ps2_clk_oe`=1 for INHIBIT_CYCLES cycles, then go to REQ.
  - REQ: one cycle with `ps2_clk_oe`=1 and `ps2_data_oe`=1 (start bit 0). Next: CLOCKING.
  - CLOCKING: `ps2_clk_oe`=0 and `ps2_data_oe` held. Count device falling edges 1..11:
    - Edges 1–8: drive data bit 0–7.
    - Edge 9: drive parity.
    - Edge 10: release data (stop bit 1).
    - Edge 11: sample synced data. 0 goes to WAIT_IDLE; 1 is a NACK and goes to ERR.
  - WAIT_IDLE: both lines released. Wait until synced clock and data are both 1, then go to DONE.
  - DONE: pulse `tx_done` for 1 cycle, then IDLE.
  - ERR: pulse `tx_err` for 1 cycle, then IDLE.
- **Line drive rule:** bit value b gives `ps2_data_oe` = ~b.
- **Timeout:** a cycle counter is cleared on entry to CLOCKING and on every detected falling edge. It also runs in WAIT_IDLE. When it reaches TIMEOUT_CYCLES, both lines are released and the block goes to ERR.
- **Busy requests:** `tx_valid` while busy is ignored, not queued. `tx_data` is sampled only at accept.
- **Reset at any time:** both `oe` outputs go to 0 and the block returns to IDLE. Any transfer in progress is abandoned with no `tx_done` and no `tx_err`.

## Timing
- **Reset values:** `ps2_clk_oe`=0, `ps2_data_oe`=0, `tx_ready`=1, `tx_done`=0, `tx_err`=0. All outputs are registered.
- **Accept:** the cycle after accept, `tx_ready`=0 and `ps2_clk_oe`=1.
- **Clock inhibit:** `ps2_clk_oe` is high for exactly INHIBIT_CYCLES+1 cycles (inhibit plus REQ).
- **Start bit:** `ps2_data_oe` rises 1 cycle before `ps2_clk_oe` falls.
- **Bit update latency:** a new data value appears at most 4 cycles after the pad falling edge (3 sync flops plus 1 register). This is far inside the device's ≥30 µs low phase.
- **Return to ready:** `tx_ready` returns to 1 in the cycle after the `tx_done`/`tx_err` pulse.
- **Exclusivity:** `tx_done` and `tx_err` are never high together.

## Structure
- Shared package `ps2_pkg` holds:
  - the state enum;
  - command constants CMD_SET_LED 8'hED, CMD_RESET 8'hFF, CMD_ENABLE 8'hF4;
  - device reply constants ACK 8'hFA, RESEND 8'hFE;
  - BREAK 8'hF0 and EXT 8'hE0, shared with the receiver.
- One sub-module, `ps2_sync_edge`: 3-flop synchronizer plus falling-edge pulse, for clock and data. The receiver reuses it.

## Test plan
- **Normal send of 8'hED.** Device model clocks at a 40 µs half period and ACKs. Required:
  - bits on the pad after edges 1..10 are 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - exactly one `tx_done` pulse;
  - `tx_err` stays 0.
- **Send of 8'h00.** Required: all data bits 0, parity 1, `tx_done` pulses once.
- **Inhibit length.** Required:
  - `ps2_clk_oe` high exactly INHIBIT_CYCLES+1 cycles;
  - `ps2_data_oe` rises one cycle before `ps2_clk_oe` falls.
- **Device never clocks.** Required:
  - `tx_err` pulses after TIMEOUT_CYCLES;
  - both `oe` are 0;
  - `tx_ready` is 1 on the following cycle.
- **Device NACK (data high at edge 11).** Required: `tx_err` pulses once, `tx_done` stays 0.
- **Held request and reset mid-byte.** Hold `tx_valid` with 8'hFF while busy, then assert `rst` after edge 5. Required:
  - the held request is not accepted while busy;
  - the cycle after reset: both `oe` are 0, `tx_ready` is 1, and no `tx_done`/`tx_err` pulse has occurred.
